uart_tx_periph: RTL and testbench

Memory-mapped UART transmitter on the processor data bus, beside the ROM, RAM and flag register. Byte stores to its data address go into a small FIFO. The block serialises each byte onto `tx` as 8N1, or 8E1 when parity is compiled in. A status address returns FIFO and line state over the same 8-bit read path that feeds the read-data multiplexer.

---
 rtl/uart_tx_periph.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_periph.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: byte FIFO at BASE_ADDR, status at BASE_ADDR+4, 8N1 serial out.
// Define UART_PARITY_EN to insert an even-parity bit after the data bits (8E1).
module uart_tx_periph #(
  parameter logic [31:0] BASE_ADDR    = 32'h4800,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [7:0]  ReadData,
  output logic        hit,
  output logic        tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state, state_d;
  logic [CW-1:0] baud_cnt, baud_d;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    shreg, shreg_d;
  logic          tx_d;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          ovf;

  logic          full_c, empty_c, baud_done_c, pop_c, push_c;
  logic          data_wr_c, stat_wr_c, unused_wdata_c;
  logic [7:0]    head_c, status_c;

  // Bus decode and FIFO flags
  assign data_wr_c      = MemWrite && (DataAdr == BASE_ADDR);
  assign stat_wr_c      = MemWrite && (DataAdr == STAT_ADDR);
  assign empty_c        = (wr_ptr == rd_ptr);
  assign full_c         = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign push_c         = data_wr_c && !full_c;
  assign head_c         = mem[rd_ptr[AW-1:0]];
  assign baud_done_c    = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign hit            = (DataAdr == BASE_ADDR) || (DataAdr == STAT_ADDR);
  assign unused_wdata_c = ^WriteData[31:8];

  // Next-state logic; shreg rotates so it holds the original byte again after bit 7
  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_idx;
    shreg_d = shreg;
    pop_c   = 1'b0;
    if (state != S_IDLE) baud_d = baud_done_c ? '0 : baud_cnt + CW'(1);
    case (state)
      S_IDLE: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          shreg_d = head_c;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done_c) state_d = S_DATA;
      end
      S_DATA: begin
        if (baud_done_c) begin
          shreg_d = {shreg[0], shreg[7:1]};
          bit_d   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (baud_done_c) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (baud_done_c) begin
          if (!empty_c) begin
            pop_c   = 1'b1;
            shreg_d = head_c;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level for the upcoming cycle, registered so tx is glitch-free
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef UART_PARITY_EN
      S_PARITY: tx_d = ^shreg_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_idx  <= bit_d;
      shreg    <= shreg_d;
      tx       <= tx_d;
    end
  end

  // FIFO pointers and sticky overflow; a drop wins over a same-edge clear
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      if (data_wr_c && full_c) ovf <= 1'b1;
      else if (stat_wr_c)      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr[AW-1:0]] <= WriteData[7:0];
  end

  // Zero-wait read path into the core's read-data mux
  always_comb begin
    status_c = {4'b0000, (state != S_IDLE), ovf, full_c, empty_c};
    ReadData = 8'h00;
    if (DataAdr == BASE_ADDR)      ReadData = empty_c ? 8'h00 : head_c;
    else if (DataAdr == STAT_ADDR) ReadData = status_c;
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: a line monitor decodes frames from tx and
// each scenario task compares them against byte queues built from the stores it issued.
`timescale 1ns/1ps
module tb_uart_tx_periph;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h4800;
  localparam logic [31:0] STAT  = 32'h4804;
`ifdef UART_PARITY_EN
  localparam int unsigned FB = 11;
`else
  localparam int unsigned FB = 10;
`endif
  localparam int unsigned FRAME = FB * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        MemWrite = 1'b0;
  logic [7:0]  ReadData;
  logic        hit, tx;

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [10:0] bits;
    int unsigned start;
    bit          glitch;
  } frame_t;
  frame_t rx_q[$];

  uart_tx_periph #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .DataAdr(DataAdr), .WriteData(WriteData),
    .MemWrite(MemWrite), .ReadData(ReadData), .hit(hit), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: a frame is FB bits of CPB cycles each, every cycle of a bit must agree
  initial begin : monitor
    forever begin
      @(posedge clk); #2;
      if (!reset && tx === 1'b0) begin
        frame_t f;
        bit abort;
        int unsigned n;
        logic [3:0] bi;
        f.bits = '1; f.start = cyc; f.glitch = 1'b0; abort = 1'b0; n = 0;
        while (n < FRAME && !abort) begin
          if (n != 0) begin @(posedge clk); #2; end
          bi = 4'(n / CPB);
          if (reset) abort = 1'b1;
          else if (n % CPB == 0) f.bits[bi] = tx;
          else if (tx !== f.bits[bi]) f.glitch = 1'b1;
          n++;
        end
        if (!abort) rx_q.push_back(f);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic store(input logic [31:0] a, input logic [7:0] d);
    DataAdr = a; WriteData = {24'($urandom), d}; MemWrite = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [7:0] v, output logic h);
    DataAdr = a; #1;
    v = ReadData; h = hit;
  endtask

  task automatic wait_rx(input int unsigned n, input int unsigned budget, input string what);
    int unsigned k = 0;
    while (rx_q.size() < n && k < budget) begin @(posedge clk); #1; k++; end
    tests++;
    if (rx_q.size() < n) begin
      fails++; $display("FAIL %s: got %0d frames, want %0d", what, rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    logic [7:0] v; logic h;
    reset = 1'b1; MemWrite = 1'b0;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", tx); end
    rd(STAT, v, h);
    tests++; if (v !== 8'h01) begin fails++; $display("FAIL reset_status: got %h want 01", v); end
    tests++; if (h !== 1'b1) begin fails++; $display("FAIL reset_hit_stat: got %b want 1", h); end
    rd(BASE, v, h);
    tests++; if (v !== 8'h00) begin fails++; $display("FAIL reset_data_empty: got %h want 00", v); end
  endtask

  task automatic test_single();
    logic [7:0] v; logic h;
    rx_q.delete();
    store(BASE, 8'h55);
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL single_pre_start: got %b want 1", tx); end
    rd(STAT, v, h);
    tests++; if (v !== 8'h00) begin fails++; $display("FAIL single_queued_status: got %h want 00", v); end
    @(posedge clk); #1;
    tests++; if (tx !== 1'b0) begin fails++; $display("FAIL single_latency: got %b want 0", tx); end
    rd(STAT, v, h);
    tests++; if (v !== 8'h09) begin fails++; $display("FAIL single_busy_status: got %h want 09", v); end
    wait_rx(1, FRAME + 10, "single_frame");
    if (rx_q.size() >= 1) begin
      tests++;
      if (rx_q[0].bits[8:1] !== 8'h55) begin
        fails++; $display("FAIL single_data: got %h want 55", rx_q[0].bits[8:1]);
      end
      tests++;
      if (rx_q[0].bits[FB-1] !== 1'b1 || rx_q[0].glitch) begin
        fails++; $display("FAIL single_stop: got stop=%b glitch=%0d want 1/0", rx_q[0].bits[FB-1], rx_q[0].glitch);
      end
    end
    @(posedge clk); #1;
    rd(STAT, v, h);
    tests++; if (v !== 8'h01) begin fails++; $display("FAIL single_idle_status: got %h want 01", v); end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 5; b++) begin
      logic [7:0] exp[$];
      int unsigned n;
      exp.delete();
      if (b == 0) exp = '{8'hA1, 8'hB2, 8'hC3};
      else begin
        n = $urandom_range(1, DEPTH);
        for (int i = 0; i < int'(n); i++) exp.push_back(8'($urandom));
      end
      rx_q.delete();
      foreach (exp[i]) store(BASE, exp[i]);
      wait_rx(exp.size(), exp.size() * FRAME + 20, "b2b_frames");
      repeat (FRAME) @(posedge clk); #1;
      tests++;
      if (rx_q.size() != exp.size()) begin
        fails++; $display("FAIL b2b_count: got %0d want %0d", rx_q.size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
        tests++;
        if (rx_q[i].bits[8:1] !== exp[i]) begin
          fails++; $display("FAIL b2b_data[%0d]: got %h want %h", i, rx_q[i].bits[8:1], exp[i]);
        end
        tests++;
        if (rx_q[i].bits[FB-1] !== 1'b1 || rx_q[i].glitch) begin
          fails++; $display("FAIL b2b_stop[%0d]: got stop=%b glitch=%0d", i, rx_q[i].bits[FB-1], rx_q[i].glitch);
        end
`ifdef UART_PARITY_EN
        tests++;
        if (rx_q[i].bits[9] !== ^exp[i]) begin
          fails++; $display("FAIL b2b_parity[%0d]: got %b want %b", i, rx_q[i].bits[9], ^exp[i]);
        end
`endif
        if (i > 0) begin
          tests++;
          if (rx_q[i].start - rx_q[i-1].start != FRAME) begin
            fails++; $display("FAIL b2b_gap[%0d]: got %0d cycles want %0d", i, rx_q[i].start - rx_q[i-1].start, FRAME);
          end
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp[$]; logic [7:0] v; logic h;
    exp.delete();
    rx_q.delete();
    for (int i = 0; i < 10; i++) exp.push_back(8'($urandom));
    for (int i = 0; i < 9; i++) store(BASE, exp[i]);
    rd(STAT, v, h);
    tests++; if (v !== 8'h0A) begin fails++; $display("FAIL ovf_full_status: got %h want 0A", v); end
    rd(BASE, v, h);
    tests++; if (v !== exp[1]) begin fails++; $display("FAIL ovf_head: got %h want %h", v, exp[1]); end
    store(BASE, exp[9]);
    rd(STAT, v, h);
    tests++; if (v !== 8'h0E) begin fails++; $display("FAIL ovf_set_status: got %h want 0E", v); end
    rd(BASE, v, h);
    tests++; if (v !== exp[1]) begin fails++; $display("FAIL ovf_head_nopop: got %h want %h", v, exp[1]); end
    store(STAT, 8'($urandom));
    rd(STAT, v, h);
    tests++; if (v !== 8'h0A) begin fails++; $display("FAIL ovf_clear_status: got %h want 0A", v); end
    wait_rx(9, 9 * FRAME + 40, "ovf_frames");
    repeat (2 * FRAME) @(posedge clk); #1;
    tests++; if (rx_q.size() != 9) begin fails++; $display("FAIL ovf_count: got %0d want 9", rx_q.size()); end
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      tests++;
      if (rx_q[i].bits[8:1] !== exp[i] || rx_q[i].glitch) begin
        fails++; $display("FAIL ovf_data[%0d]: got %h want %h", i, rx_q[i].bits[8:1], exp[i]);
      end
      if (i > 0) begin
        tests++;
        if (rx_q[i].start - rx_q[i-1].start != FRAME) begin
          fails++; $display("FAIL ovf_gap[%0d]: got %0d want %0d", i, rx_q[i].start - rx_q[i-1].start, FRAME);
        end
      end
    end
    rd(STAT, v, h);
    tests++; if (v !== 8'h01) begin fails++; $display("FAIL ovf_end_status: got %h want 01", v); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] v; logic h;
    int low_cycles = 0;
    rx_q.delete();
    store(BASE, 8'h3C);
    store(BASE, 8'($urandom));
    store(BASE, 8'($urandom));
    repeat (6) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL rstmid_tx: got %b want 1", tx); end
    rd(STAT, v, h);
    tests++; if (v !== 8'h01) begin fails++; $display("FAIL rstmid_status: got %h want 01", v); end
    for (int i = 0; i < int'(3 * FRAME); i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) low_cycles++;
    end
    tests++; if (low_cycles != 0) begin fails++; $display("FAIL rstmid_quiet: got %0d low cycles want 0", low_cycles); end
    tests++; if (rx_q.size() != 0) begin fails++; $display("FAIL rstmid_frames: got %0d want 0", rx_q.size()); end
  endtask

  task automatic test_decode();
    logic [31:0] addrs[$]; logic [31:0] a; logic [7:0] v; logic h;
    addrs = '{32'h4000, 32'h4600, 32'h4801, 32'h4805, 32'h4808};
    for (int i = 0; i < 3; i++) begin
      do a = $urandom; while (a == BASE || a == STAT);
      addrs.push_back(a);
    end
    rx_q.delete();
    foreach (addrs[i]) begin
      rd(addrs[i], v, h);
      tests++;
      if (h !== 1'b0 || v !== 8'h00) begin
        fails++; $display("FAIL decode_miss[%h]: got hit=%b data=%h want 0/00", addrs[i], h, v);
      end
      store(addrs[i], 8'($urandom));
    end
    rd(STAT, v, h);
    tests++; if (v !== 8'h01) begin fails++; $display("FAIL decode_fifo: got %h want 01", v); end
    rd(BASE, v, h);
    tests++; if (h !== 1'b1) begin fails++; $display("FAIL decode_hit_base: got %b want 1", h); end
    repeat (FRAME) @(posedge clk); #1;
    tests++; if (rx_q.size() != 0) begin fails++; $display("FAIL decode_frames: got %0d want 0", rx_q.size()); end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    logic [10:0] want;
    want = {1'b1, 1'b1, 8'h07, 1'b0};
    rx_q.delete();
    store(BASE, 8'h07);
    wait_rx(1, FRAME + 10, "parity_frame");
    if (rx_q.size() >= 1) begin
      tests++;
      if (rx_q[0].bits !== want || rx_q[0].glitch) begin
        fails++; $display("FAIL parity_frame_bits: got %b want %b", rx_q[0].bits, want);
      end
    end
    repeat (4) @(posedge clk); #1;
  endtask
`endif

  initial begin : main
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_decode();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
